// File: rtl/camera_config_sequencer.sv
`default_nettype none
// ============================================================================
// camera_config_sequencer
//   Walks a ROM register list and issues one SCCB write per entry, with
//   in-list delay and end-of-list markers; raises o_done when finished.
//   Revision: 1.0
// ============================================================================
module camera_config_sequencer #(
  parameter int CLK_FREQUENCY = 25000000,
  parameter int ROM_DEPTH     = 256,
  parameter int DELAY_MS      = 10
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  output logic [$clog2(ROM_DEPTH)-1:0] o_rom_addr,
  input  logic [15:0]                  i_rom_data,
  input  logic                         i_tx_ready,
  output logic                         o_tx_start,
  output logic [7:0]                   o_tx_address,
  output logic [7:0]                   o_tx_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(ROM_DEPTH):0]   o_write_count
);

  localparam int AW           = $clog2(ROM_DEPTH);
  localparam int CW           = AW + 1;
  localparam int DELAY_CYCLES = CLK_FREQUENCY / 1000 * DELAY_MS;
  localparam int DW           = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [15:0]   C_END_WORD   = 16'hFFFF;
  localparam logic [15:0]   C_DELAY_WORD = 16'hFFF0;
  localparam logic [DW-1:0] C_DELAY_LOAD = DW'(DELAY_CYCLES - 1);
  localparam logic [AW-1:0] C_LAST_ADDR  = AW'(ROM_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FETCH       = 4'd1,
    S_DECODE      = 4'd2,
    S_SEND        = 4'd3,
    S_WAIT_ACCEPT = 4'd4,
    S_WAIT_DONE   = 4'd5,
    S_DELAY       = 4'd6,
    S_ADVANCE     = 4'd7,
    S_DONE        = 4'd8
  } state_t;

  state_t        state_q;
  logic [AW-1:0] rom_addr_q;
  logic          tx_start_q;
  logic [7:0]    tx_address_q;
  logic [7:0]    tx_data_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] write_count_q;
  logic [DW-1:0] delay_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_address_q  <= '0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      write_count_q <= '0;
      delay_cnt_q   <= '0;
    end else begin
      // The start strobe is only ever raised for the single SEND->WAIT_ACCEPT edge.
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            rom_addr_q    <= '0;
            write_count_q <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == C_END_WORD) begin
            state_q <= S_DONE;
          end else if (i_rom_data == C_DELAY_WORD) begin
            delay_cnt_q <= C_DELAY_LOAD;
            state_q     <= S_DELAY;
          end else begin
            tx_address_q <= i_rom_data[15:8];
            tx_data_q    <= i_rom_data[7:0];
            state_q      <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_tx_ready) begin
            tx_start_q <= 1'b1;
            state_q    <= S_WAIT_ACCEPT;
          end
        end
        S_WAIT_ACCEPT: begin
          if (!i_tx_ready) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_ready) begin
            write_count_q <= write_count_q + CW'(1);
            state_q       <= S_ADVANCE;
          end
        end
        S_DELAY: begin
          if (delay_cnt_q == '0) state_q <= S_ADVANCE;
          else                   delay_cnt_q <= delay_cnt_q - DW'(1);
        end
        S_ADVANCE: begin
          // Running off the end of the ROM terminates the list; no wrap.
          if (rom_addr_q == C_LAST_ADDR) begin
            state_q <= S_DONE;
          end else begin
            rom_addr_q <= rom_addr_q + AW'(1);
            state_q    <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (i_start) begin
            rom_addr_q    <= '0;
            write_count_q <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr    = rom_addr_q;
  assign o_tx_start    = tx_start_q;
  assign o_tx_address  = tx_address_q;
  assign o_tx_data     = tx_data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_write_count = write_count_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_config_sequencer.sv
`default_nettype none
// Bench for camera_config_sequencer: ROM + transmitter models, list-walking
// scoreboard, and directed scenarios with hand-computed timing.
module tb_camera_config_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_address;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [2:0]  write_count;

  camera_config_sequencer #(
    .CLK_FREQUENCY(100000),
    .ROM_DEPTH    (DEPTH),
    .DELAY_MS     (1)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_start      (start),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .i_tx_ready   (tx_ready),
    .o_tx_start   (tx_start),
    .o_tx_address (tx_address),
    .o_tx_data    (tx_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_write_count(write_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: one cycle of read latency.
  logic [15:0] rom [DEPTH];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Transmitter: ready drops the edge after a start pulse, returns 40 cycles later.
  logic tx_hold = 1'b0;
  int   tx_busy = 0;
  always @(posedge clk) begin
    if (tx_hold) tx_ready <= 1'b0;
    else if (tx_start) begin
      tx_ready <= 1'b0;
      tx_busy  <= 40;
    end else if (tx_busy > 0) begin
      tx_busy <= tx_busy - 1;
      if (tx_busy == 1) tx_ready <= 1'b1;
    end else tx_ready <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: walk the list to derive the writes, final address and final count.
  logic [15:0] exp_q[$];
  int exp_cnt;
  int exp_addr;
  task automatic build_expected();
    exp_q.delete();
    exp_addr = DEPTH - 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (rom[a] == 16'hFFFF) begin
        exp_addr = a;
        break;
      end
      if (rom[a] != 16'hFFF0) exp_q.push_back(rom[a]);
    end
    exp_cnt = exp_q.size();
  endtask

  // Per-cycle compare against the model.
  int   pulses = 0;
  int   first_pulse_cyc = 0;
  int   done_cyc = 0;
  logic last_start = 1'b0;
  logic last_ready = 1'b1;
  logic last_done = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_q.size() == 0) chk("unexpected_start", {tx_address, tx_data}, 16'h0000);
      else chk("write_addr_data", {tx_address, tx_data}, exp_q.pop_front());
      chk("start_not_back_to_back", {31'd0, last_start}, 0);
      chk("start_only_when_ready", {31'd0, last_ready}, 1);
      if (pulses == 0) first_pulse_cyc <= cyc;
      pulses <= pulses + 1;
    end
    if (done && !last_done) done_cyc <= cyc;
    if (reset_n) chk("busy_done_exclusive", {31'd0, busy & done}, 0);
    last_start <= tx_start;
    last_ready <= tx_ready;
    last_done  <= done;
  end

  int t0 = 0;
  task automatic run(input int hold);
    build_expected();
    pulses = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("run_addr0", {30'd0, rom_addr}, 0);
    chk("run_busy", {31'd0, busy}, 1);
    chk("run_done_clear", {31'd0, done}, 0);
    for (int i = 0; i < hold; i++) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_within_bound", {31'd0, done}, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_count"}, {29'd0, write_count}, exp_cnt);
    chk({tag, "_addr"}, {30'd0, rom_addr}, exp_addr);
    chk({tag, "_pulses"}, pulses, exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, {30'd0, rom_addr}, 0);
    chk({tag, "_start"}, {31'd0, tx_start}, 0);
    chk({tag, "_txaddr"}, {24'd0, tx_address}, 0);
    chk({tag, "_txdata"}, {24'd0, tx_data}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_count"}, {29'd0, write_count}, 0);
  endtask

  task automatic load(input logic [15:0] w0, w1, w2, w3);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  initial begin
    load(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic three-entry list.
    run(0);
    wait_done(300);
    check_end("list3");
    chk("list3_first_pulse_latency", first_pulse_cyc - t0, 3);
    chk("list3_count_lit", {29'd0, write_count}, 2);
    chk("list3_addr_lit", {30'd0, rom_addr}, 2);
    chk("list3_last_data", {tx_address, tx_data}, 16'h1101);

    // Delay marker followed by a write.
    load(16'hFFF0, 16'h3A04, 16'hFFFF, 16'h0000);
    run(0);
    wait_done(400);
    check_end("delay");
    chk("delay_min_gap", {31'd0, (first_pulse_cyc - t0) >= 102}, 1);
    chk("delay_exact_latency", first_pulse_cyc - t0, 106);

    // End marker first: nothing written.
    load(16'hFFFF, 16'h5555, 16'h6666, 16'h7777);
    run(0);
    wait_done(50);
    check_end("end0");
    chk("end0_done_latency", done_cyc - t0, 3);

    // No terminator: runs to the last address and holds there.
    load(16'h0111, 16'h0222, 16'h0333, 16'h0444);
    run(0);
    wait_done(400);
    check_end("noterm");
    chk("noterm_count_lit", {29'd0, write_count}, 4);
    repeat (5) @(negedge clk);
    chk("noterm_addr_holds", {30'd0, rom_addr}, 3);
    chk("noterm_done_held", {31'd0, done}, 1);

    // Transmitter not ready at SEND for 20 cycles.
    load(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    tx_hold = 1'b1;
    run(0);
    repeat (20) @(negedge clk);
    chk("hold_no_pulse", pulses, 0);
    chk("hold_start_low", {31'd0, tx_start}, 0);
    tx_hold = 1'b0;
    wait_done(300);
    check_end("hold");

    // Reset while waiting for the transmitter to finish.
    run(0);
    for (int i = 0; i < 100 && pulses == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    @(negedge clk);
    run(0);
    wait_done(400);
    check_end("restart");

    // Start held high during a run is ignored; a new start in DONE reruns.
    run(60);
    wait_done(300);
    check_end("heldstart");
    run(0);
    wait_done(300);
    check_end("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
